reset_sequencer: RTL and testbench

Downstream consumer of the watchdog's `system_reset` output and of a software reset request. It converts either trigger into an ordered, timed reset of the plant-monitor subsystems: sensor front-end, then actuators (pump/lights), then comms. The block holds all domains in reset for a minimum time, releases them one at a time, and records reset count and cause for telemetry.

---
 rtl/reset_seq_pkg.sv | 26 ++
 rtl/rst_seq_timer.sv | 40 ++++
 rtl/reset_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM states, reset-cause
// encodings and the timer width calculation.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        LOCKED  = 2'd3
    } seq_state_e;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_WDT  = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;
    localparam logic [1:0] CAUSE_BOTH = 2'b11;

    function automatic int timer_width(input int hold_cycles,
                                       input int num_domains,
                                       input int stage_delay);
        int span;
        span = (hold_cycles > num_domains * stage_delay) ? hold_cycles
                                                          : num_domains * stage_delay;
        return $clog2(span + 2);
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable up-counter with synchronous clear and an equality compare against
// a caller-supplied terminal value.
module rst_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] cmp_i,
    output logic         hit_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear beats load beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == cmp_i);

endmodule

// File: rtl/reset_sequencer.sv
// Ordered, timed release of plant-monitor reset domains after a watchdog or
// software trigger. Optional storm lockout is enabled by RESET_STORM_LOCK_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 1000,
    parameter int STAGE_DELAY = 100,
    parameter int CNT_W       = 8,
    parameter int STORM_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wdt_reset,
    input  logic                   sw_reset_req,
    input  logic                   cause_clear,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   seq_busy,
    output logic [CNT_W-1:0]       reset_count,
    output logic [1:0]             last_cause,
    output logic                   storm_lock
);

    localparam int TW    = timer_width(HOLD_CYCLES, NUM_DOMAINS, STAGE_DELAY);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [TW-1:0]    HOLD_CMP  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]    STAGE_CMP = TW'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

    if (HOLD_CYCLES < 1 || STAGE_DELAY < 1 || NUM_DOMAINS < 1 || STORM_LIMIT < 1) begin : g_param_check
        $error("reset_sequencer: HOLD_CYCLES, STAGE_DELAY, NUM_DOMAINS and STORM_LIMIT must be >= 1");
    end

    seq_state_e             state_q, state_d;
    logic                   wdt_prev_q;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [1:0]             cause_q, cause_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   window_q, window_d;

    logic wdt_rise, trig;
    logic tmr_clr, tmr_load, tmr_en, tmr_hit;
    logic [TW-1:0] tmr_cmp;

`ifdef RESET_STORM_LOCK_EN
    localparam int SW_W = $clog2(STORM_LIMIT + 1);
    logic [SW_W-1:0] storm_q, storm_d;
    logic            lock_q, lock_d;
`endif

    assign wdt_rise = wdt_reset & ~wdt_prev_q;
    assign trig     = wdt_rise | sw_reset_req;

    rst_seq_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (reset),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (STAGE_CMP),
        .en_i       (tmr_en),
        .cmp_i      (tmr_cmp),
        .hit_o      (tmr_hit)
    );

    always_comb begin
        state_d  = state_q;
        dom_d    = dom_q;
        busy_d   = busy_q;
        count_d  = count_q;
        cause_d  = cause_q;
        idx_d    = idx_q;
        window_d = window_q;
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_cmp  = HOLD_CMP;
`ifdef RESET_STORM_LOCK_EN
        storm_d  = storm_q;
        lock_d   = lock_q;
`endif

        if (trig) begin
            count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
            if (wdt_rise && sw_reset_req) cause_d = CAUSE_BOTH;
            else if (sw_reset_req)        cause_d = CAUSE_SW;
            else                          cause_d = CAUSE_WDT;
        end else if (cause_clear) begin
            cause_d = CAUSE_NONE;
        end

        case (state_q)
            HOLD: begin
                tmr_en = 1'b1;
                if (tmr_hit) begin
                    // Preload so the first RELEASE edge frees domain 0.
                    state_d  = RELEASE;
                    tmr_load = 1'b1;
                    idx_d    = '0;
                end
            end
            RELEASE: begin
                tmr_cmp = STAGE_CMP;
                tmr_en  = 1'b1;
                if (tmr_hit) begin
                    dom_d[idx_q] = 1'b1;
                    tmr_clr      = 1'b1;
                    idx_d        = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d  = RUN;
                        busy_d   = 1'b0;
                        window_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // The timer is reused to measure the post-release storm window.
                if (window_q) begin
                    tmr_en = 1'b1;
                    if (tmr_hit) begin
                        window_d = 1'b0;
`ifdef RESET_STORM_LOCK_EN
                        storm_d  = '0;
`endif
                    end
                end
            end
            default: ;
        endcase

        if (trig && state_q != LOCKED) begin
            state_d  = HOLD;
            dom_d    = '0;
            busy_d   = 1'b1;
            tmr_clr  = 1'b1;
            tmr_load = 1'b0;
            window_d = 1'b0;
            idx_d    = '0;
`ifdef RESET_STORM_LOCK_EN
            if (busy_q || window_q) begin
                storm_d = storm_q + SW_W'(1);
                if (int'(storm_q) + 1 >= STORM_LIMIT) begin
                    state_d = LOCKED;
                    lock_d  = 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= HOLD;
            wdt_prev_q <= 1'b0;
            dom_q      <= '0;
            busy_q     <= 1'b1;
            count_q    <= '0;
            cause_q    <= CAUSE_NONE;
            idx_q      <= '0;
            window_q   <= 1'b0;
`ifdef RESET_STORM_LOCK_EN
            storm_q    <= '0;
            lock_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wdt_prev_q <= wdt_reset;
            dom_q      <= dom_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
            cause_q    <= cause_d;
            idx_q      <= idx_d;
            window_q   <= window_d;
`ifdef RESET_STORM_LOCK_EN
            storm_q    <= storm_d;
            lock_q     <= lock_d;
`endif
        end
    end

    assign domain_rst_n = dom_q;
    assign seq_busy     = busy_q;
    assign reset_count  = count_q;
    assign last_cause   = cause_q;
`ifdef RESET_STORM_LOCK_EN
    assign storm_lock   = lock_q;
`else
    assign storm_lock   = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: an edge-counting reference model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_reset_sequencer;

    localparam int N     = 3;
    localparam int HOLD  = 16;
    localparam int SD    = 4;
    localparam int CW    = 8;
    localparam int LIMIT = 4;
    localparam int W     = N + 1 + CW + 2 + 1;
    localparam int R_RUN = HOLD + 1 + (N - 1) * SD;
`ifdef RESET_STORM_LOCK_EN
    localparam bit STORM_EN = 1'b1;
`else
    localparam bit STORM_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          wdt_reset;
    logic          sw_reset_req;
    logic          cause_clear;
    logic [N-1:0]  domain_rst_n;
    logic          seq_busy;
    logic [CW-1:0] reset_count;
    logic [1:0]    last_cause;
    logic          storm_lock;

    reset_sequencer #(
        .NUM_DOMAINS (N),
        .HOLD_CYCLES (HOLD),
        .STAGE_DELAY (SD),
        .CNT_W       (CW),
        .STORM_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wdt_reset    (wdt_reset),
        .sw_reset_req (sw_reset_req),
        .cause_clear  (cause_clear),
        .domain_rst_n (domain_rst_n),
        .seq_busy     (seq_busy),
        .reset_count  (reset_count),
        .last_cause   (last_cause),
        .storm_lock   (storm_lock)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    wire [W-1:0] act = {domain_rst_n, seq_busy, reset_count, last_cause, storm_lock};
    localparam logic [W-1:0] RESET_VAL = {{N{1'b0}}, 1'b1, {CW{1'b0}}, 2'b00, 1'b0};

    // ---------------- reference model ----------------
    // e = edges since the most recent entry into the all-in-reset hold.
    int e;
    bit m_wprev;
    int m_cnt;
    int m_cause;
    int m_storm;
    bit m_locked;

    task automatic model_reset();
        e = 0; m_wprev = 0; m_cnt = 0; m_cause = 0; m_storm = 0; m_locked = 0;
    endtask

    task automatic model_edge(input bit w, input bit s, input bit c);
        bit rise, trig;
        rise = w && !m_wprev;
        trig = rise || s;
        m_wprev = w;
        if (trig) begin
            m_cnt   = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
            m_cause = (s ? 2 : 0) + (rise ? 1 : 0);
        end else if (c) begin
            m_cause = 0;
        end
        if (m_locked) return;
        if (trig) begin
            if (STORM_EN && e < R_RUN + HOLD) begin
                m_storm++;
                if (m_storm >= LIMIT) m_locked = 1;
            end
            e = 0;
        end else begin
            if (e < 100000) e++;
            if (STORM_EN && e == R_RUN + HOLD) m_storm = 0;
        end
    endtask

    function automatic logic [W-1:0] model_out();
        logic [N-1:0] dom;
        logic busy, lock;
        for (int i = 0; i < N; i++) dom[i] = (e >= HOLD + 1 + i * SD);
        busy = (e < R_RUN);
        lock = 1'b0;
        if (m_locked) begin
            dom = '0; busy = 1'b1; lock = 1'b1;
        end
        return {dom, busy, CW'(m_cnt), 2'(m_cause), lock};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input bit w, input bit s, input bit c);
        wdt_reset = w; sw_reset_req = s; cause_clear = c;
        @(posedge clk);
        cycle++;
        model_edge(w, s, c);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic check_now(input string name, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Async reset asserted mid-cycle; outputs must drop before the next edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_now("async_reset", RESET_VAL);
        @(posedge clk);
        #1;
        check_now("reset_held", RESET_VAL);
        reset = 1'b1;
        model_reset();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] exp;
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL outputs cycle %0d got dom=%b busy=%b cnt=%0d cause=%b lock=%b expected dom=%b busy=%b cnt=%0d cause=%b lock=%b",
                         cycle, act[W-1 -: N], act[W-1-N], act[CW+2:3], act[2:1], act[0],
                         exp[W-1 -: N], exp[W-1-N], exp[CW+2:3], exp[2:1], exp[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit wl;
        reset = 1'b0; wdt_reset = 1'b0; sw_reset_req = 1'b0; cause_clear = 1'b0;
        @(posedge clk);
        #1;
        check_now("power_on_reset", RESET_VAL);
        reset = 1'b1;
        model_reset();

        // Power-on release sequence, then settle in RUN.
        repeat (30) step(0, 0, 0);

        // Watchdog level held high from RUN: one trigger only.
        repeat (50) step(1, 0, 0);
        repeat (40) step(0, 0, 0);

        // Reset from RUN, then reset again in the middle of RELEASE.
        do_reset();
        repeat (20) step(0, 0, 0);
        do_reset();

        // Software request on edge 19 after domain 0 is already out.
        repeat (18) step(0, 0, 0);
        step(0, 1, 0);
        repeat (40) step(0, 0, 0);

        // Simultaneous causes with a competing clear, then a lone clear.
        step(1, 1, 1);
        repeat (10) step(1, 0, 0);
        repeat (40) step(0, 0, 0);
        step(0, 0, 1);
        repeat (3) step(0, 0, 0);

        // Counter saturation.
        do_reset();
        repeat (260) begin
            step(0, 1, 0);
            step(0, 0, 0);
        end
        repeat (30) step(0, 0, 0);

        // Storm stimulus: four pulses five edges apart.
        do_reset();
        repeat (LIMIT) begin
            step(0, 1, 0);
            repeat (4) step(0, 0, 0);
        end
        repeat (60) step(0, 0, 0);

        // Randomized mix of all inputs.
        do_reset();
        wl = 1'b0;
        repeat (1500) begin
            if ($urandom_range(0, 119) == 0) wl = ~wl;
            step(wl, ($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0));
        end
        step(0, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
